// File: rtl/id_ex_seq_reg_if.sv
// Decode-to-execute bundle: decoded control word and PC/flags going in, the
// registered control word and stack-sequencer outputs coming out.
interface id_ex_seq_reg_if #(
  parameter int CTRL_W = 14,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
);
  logic [CTRL_W-1:0] ctrl_in;
  logic [1:0]        state_in;
  logic              valid_in;
  logic [PC_W-1:0]   pc_in;
  logic [FLAG_W-1:0] flags_in;
  logic              hold;
  logic              flush;

  logic [CTRL_W-1:0] ctrl_out;
  logic [1:0]        state_out;
  logic              valid_out;
  logic [1:0]        step;
  logic [15:0]       push_data;
  logic              stall_fetch;
  logic              seq_busy;

  modport master (
    output ctrl_in, state_in, valid_in, pc_in, flags_in, hold, flush,
    input  ctrl_out, state_out, valid_out, step, push_data, stall_fetch, seq_busy
  );

  modport slave (
    input  ctrl_in, state_in, valid_in, pc_in, flags_in, hold, flush,
    output ctrl_out, state_out, valid_out, step, push_data, stall_fetch, seq_busy
  );
endinterface

// File: rtl/id_ex_seq_reg.sv
// ID/EX pipeline register that also sequences the multi-cycle stack pushes of
// CALL/RET (two steps) and interrupt/RETI (three steps), stalling fetch meanwhile.
module id_ex_seq_reg #(
  parameter int CTRL_W = 14,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 3
) (
  input logic            clk,
  input logic            rst,
  id_ex_seq_reg_if.slave bus
);

  typedef enum logic {IDLE, SEQ} fsm_t;

  fsm_t              fsm_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [1:0]        state_p1;
  logic              vld_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [FLAG_W-1:0] flags_p1;
  logic [1:0]        step_p1;
  logic [1:0]        last_p1;
  logic [1:0]        last_in;

  // Index of the final sub-step for a sequencing class; reserved 01 is single-step.
  function automatic logic [1:0] last_step(input logic [1:0] st);
    logic [1:0] r;
    case (st)
      2'b10:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Stack word per step: return PC high half, low half, then the saved flags.
  function automatic logic [15:0] stack_word(
    input logic              vld,
    input logic [1:0]        st,
    input logic [1:0]        idx,
    input logic [PC_W-1:0]   pc,
    input logic [FLAG_W-1:0] fl
  );
    logic [15:0] w;
    w = '0;
    if (vld && st[1]) begin
      case (idx)
        2'd0:    w = pc[31:16];
        2'd1:    w = pc[15:0];
        2'd2:    if (st[0]) w[FLAG_W-1:0] = fl;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign last_in = last_step(bus.state_in);

  // Stage p1: capture in IDLE, advance the sub-step in SEQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_p1   <= IDLE;
      ctrl_p1  <= '0;
      state_p1 <= '0;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      flags_p1 <= '0;
      step_p1  <= '0;
      last_p1  <= '0;
    end else if (bus.flush) begin
      fsm_p1   <= IDLE;
      ctrl_p1  <= '0;
      state_p1 <= '0;
      vld_p1   <= 1'b0;
      step_p1  <= '0;
      last_p1  <= '0;
    end else if (!bus.hold) begin
      case (fsm_p1)
        IDLE: begin
          ctrl_p1  <= bus.valid_in ? bus.ctrl_in : '0;
          state_p1 <= bus.valid_in ? bus.state_in : 2'b00;
          vld_p1   <= bus.valid_in;
          pc_p1    <= bus.pc_in;
          flags_p1 <= bus.flags_in;
          step_p1  <= '0;
          last_p1  <= last_in;
          if (bus.valid_in && (last_in != 2'd0)) fsm_p1 <= SEQ;
        end
        SEQ: begin
          step_p1 <= step_p1 + 2'd1;
          if ((step_p1 + 2'd1) == last_p1) fsm_p1 <= IDLE;
        end
        default: fsm_p1 <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_out    = ctrl_p1;
  assign bus.state_out   = state_p1;
  assign bus.valid_out   = vld_p1;
  assign bus.step        = step_p1;
  assign bus.seq_busy    = (fsm_p1 == SEQ);
  assign bus.stall_fetch = (fsm_p1 == SEQ);
  assign bus.push_data   = stack_word(vld_p1, state_p1, step_p1, pc_p1, flags_p1);

endmodule
